// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: reset level, forwarding-select codes
// and the packed ID/EX register payload.
package id_ex_stage_pkg;

  localparam logic RESET = 1'b0;

  localparam int ID_EX_ADDR_W = 5;
  localparam int ID_EX_DATA_W = 32;
  localparam int ID_EX_CTRL_W = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic [ID_EX_DATA_W-1:0] pc;
    logic [ID_EX_DATA_W-1:0] op1;
    logic [ID_EX_DATA_W-1:0] op2;
    logic [ID_EX_DATA_W-1:0] imm;
    logic [ID_EX_ADDR_W-1:0] rd;
    logic                    reg_write;
    logic                    mem_read;
    logic [ID_EX_CTRL_W-1:0] ctrl;
  } id_ex_t;

  // A bubble keeps the stale payload but must never look like a producer.
  function automatic id_ex_t id_ex_bubble(input id_ex_t cur);
    id_ex_t b;
    b           = cur;
    b.reg_write = 1'b0;
    b.mem_read  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/operand_forward.sv
// Per-operand forwarding mux and load-use hazard detection against the
// instruction held in ID/EX and the one in MEM.
module operand_forward
  import id_ex_stage_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ID_EX_ADDR_W,
  parameter int DATA_WIDTH    = ID_EX_DATA_W
) (
  input  logic [ADDRESS_WIDTH-1:0] rs,
  input  logic                     uses_rs,
  input  logic [DATA_WIDTH-1:0]    rf_data,
  input  logic                     ex_valid,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_read,
  input  logic [ADDRESS_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0]    ex_fwd_data,
  input  logic                     mem_valid,
  input  logic                     mem_reg_write,
  input  logic                     mem_mem_read,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_fwd_data,
  output logic [DATA_WIDTH-1:0]    fwd_data,
  output fwd_sel_e                 fwd_sel,
  output logic                     hazard
);

  logic rs_live;
  logic ex_match;
  logic mem_match;

  // x0 and unread sources never depend on anything in flight.
  assign rs_live   = uses_rs & (rs != '0);
  assign ex_match  = rs_live & ex_valid & (ex_rd == rs);
  assign mem_match = rs_live & mem_valid & (mem_rd == rs);

  always_comb begin
    fwd_sel  = FWD_RF;
    fwd_data = rf_data;
    if (ex_match & ex_reg_write & ~ex_mem_read) begin
      fwd_sel  = FWD_EX;
      fwd_data = ex_fwd_data;
    end else if (mem_match & mem_reg_write & ~mem_mem_read) begin
      fwd_sel  = FWD_MEM;
      fwd_data = mem_fwd_data;
    end
  end

  // Load data is not available until WB, so a load in EX or MEM stalls.
  assign hazard = (ex_match & ex_mem_read) | (mem_match & mem_mem_read);

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: register-file addressing, EX/MEM forwarding,
// load-use stall and the ID/EX pipeline register with valid/ready.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ID_EX_ADDR_W,
  parameter int DATA_WIDTH    = ID_EX_DATA_W,
  parameter int CTRL_WIDTH    = ID_EX_CTRL_W
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [ADDRESS_WIDTH-1:0] id_rs1,
  input  logic [ADDRESS_WIDTH-1:0] id_rs2,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [ADDRESS_WIDTH-1:0] id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [CTRL_WIDTH-1:0]    id_ctrl,

  output logic [ADDRESS_WIDTH-1:0] rf_read1_id,
  output logic [ADDRESS_WIDTH-1:0] rf_read2_id,
  input  logic [DATA_WIDTH-1:0]    rf_read1_data,
  input  logic [DATA_WIDTH-1:0]    rf_read2_data,

  input  logic [DATA_WIDTH-1:0]    ex_fwd_data,
  input  logic                     mem_valid,
  input  logic                     mem_reg_write,
  input  logic                     mem_mem_read,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_fwd_data,

  input  logic                     flush,

  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_op1,
  output logic [DATA_WIDTH-1:0]    ex_op2,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [ADDRESS_WIDTH-1:0] ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic [CTRL_WIDTH-1:0]    ex_ctrl
);

  logic   ex_valid_reg;
  id_ex_t ex_reg;
  id_ex_t ex_next;

  logic [ADDRESS_WIDTH-1:0] rs_arr   [2];
  logic                     uses_arr [2];
  logic [DATA_WIDTH-1:0]    rf_arr   [2];
  logic [DATA_WIDTH-1:0]    op_arr   [2];
  fwd_sel_e                 sel_arr  [2];
  logic                     hz_arr   [2];

  logic advance;
  logic hz;
  logic load_en;
  logic unused_fwd_sel;

  assign rf_read1_id = id_rs1;
  assign rf_read2_id = id_rs2;

  assign rs_arr[0]   = id_rs1;
  assign rs_arr[1]   = id_rs2;
  assign uses_arr[0] = id_uses_rs1;
  assign uses_arr[1] = id_uses_rs2;
  assign rf_arr[0]   = rf_read1_data;
  assign rf_arr[1]   = rf_read2_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      operand_forward #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
      ) u_fwd (
        .rs            (rs_arr[gi]),
        .uses_rs       (uses_arr[gi]),
        .rf_data       (rf_arr[gi]),
        .ex_valid      (ex_valid_reg),
        .ex_reg_write  (ex_reg.reg_write),
        .ex_mem_read   (ex_reg.mem_read),
        .ex_rd         (ex_reg.rd),
        .ex_fwd_data   (ex_fwd_data),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_rd        (mem_rd),
        .mem_fwd_data  (mem_fwd_data),
        .fwd_data      (op_arr[gi]),
        .fwd_sel       (sel_arr[gi]),
        .hazard        (hz_arr[gi])
      );
    end
  endgenerate

  // Select codes are only of interest on a waveform viewer.
  assign unused_fwd_sel = ^{sel_arr[0], sel_arr[1]};

  assign advance  = ~ex_valid_reg | ex_ready;
  assign hz       = hz_arr[0] | hz_arr[1];
  assign id_ready = advance & ~hz & ~flush;
  assign load_en  = advance & id_valid & ~hz;

  always_comb begin
    ex_next           = '0;
    ex_next.pc        = id_pc;
    ex_next.op1       = op_arr[0];
    ex_next.op2       = op_arr[1];
    ex_next.imm       = id_imm;
    ex_next.rd        = id_rd;
    ex_next.reg_write = id_reg_write;
    ex_next.mem_read  = id_mem_read;
    ex_next.ctrl      = id_ctrl;
  end

  // Priority: reset, flush, stall (hold), load, otherwise bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      ex_valid_reg <= 1'b0;
      ex_reg       <= '0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
      ex_reg       <= id_ex_bubble(ex_reg);
    end else if (advance) begin
      if (load_en) begin
        ex_valid_reg <= 1'b1;
        ex_reg       <= ex_next;
      end else begin
        ex_valid_reg <= 1'b0;
        ex_reg       <= id_ex_bubble(ex_reg);
      end
    end
  end

  assign ex_valid     = ex_valid_reg;
  assign ex_pc        = ex_reg.pc;
  assign ex_op1       = ex_reg.op1;
  assign ex_op2       = ex_reg.op2;
  assign ex_imm       = ex_reg.imm;
  assign ex_rd        = ex_reg.rd;
  assign ex_reg_write = ex_reg.reg_write;
  assign ex_mem_read  = ex_reg.mem_read;
  assign ex_ctrl      = ex_reg.ctrl;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the RISC-V core.
- Drives register-file read addresses from the decoded instruction, resolves operands with EX/MEM forwarding, detects load-use hazards, and registers the bundle into the ID/EX register.
- Uses a valid/ready handshake toward execute and supports flush on redirect.

Parameters:
- ADDRESS_WIDTH, 5, register index width
- DATA_WIDTH, 32, operand/PC width
- CTRL_WIDTH, 16, opaque decoded control bundle width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (common::RESET = 1'b0)
id_valid  in  1  decoded instruction present
id_ready  out  1  stage accepts decoded instruction this cycle
id_pc  in  DATA_WIDTH  instruction PC
id_rs1, id_rs2  in  ADDRESS_WIDTH  source indices
id_uses_rs1, id_uses_rs2  in  1  source actually read
id_rd  in  ADDRESS_WIDTH  destination index
id_reg_write  in  1  writes rd
id_mem_read  in  1  instruction is a load
id_imm  in  DATA_WIDTH  decoded immediate
id_ctrl  in  CTRL_WIDTH  control bundle, passed through
rf_read1_id, rf_read2_id  out  ADDRESS_WIDTH  register-file read addresses (= id_rs1/id_rs2, combinational)
rf_read1_data, rf_read2_data  in  DATA_WIDTH  register-file read data (already WB-bypassed)
ex_fwd_data  in  DATA_WIDTH  ALU result of the instruction currently held in this stage's output
mem_valid, mem_reg_write, mem_mem_read  in  1  MEM-stage status
mem_rd  in  ADDRESS_WIDTH  MEM-stage destination
mem_fwd_data  in  DATA_WIDTH  MEM-stage result (non-load)
flush  in  1  redirect from execute; kill ID and ID/EX contents
ex_valid  out  1  ID/EX register holds an instruction
ex_ready  in  1  execute consumes ID/EX this cycle
ex_pc, ex_op1, ex_op2, ex_imm  out  DATA_WIDTH  registered payload
ex_rd  out  ADDRESS_WIDTH  registered destination
ex_reg_write, ex_mem_read  out  1  registered flags
ex_ctrl  out  CTRL_WIDTH  registered control

Behaviour:
- Reset (rst=0, async): ex_valid=0; all ex_* payload and flags = 0.
- Latency: one cycle, ID to ex_* on an advancing edge.
- advance = !ex_valid | ex_ready.
- Per-operand forward select, only when uses_rsN=1 and rsN != 0:
  - EX: ex_valid & ex_reg_write & !ex_mem_read & ex_rd==rsN, selects ex_fwd_data.
  - else MEM: mem_valid & mem_reg_write & !mem_mem_read & mem_rd==rsN, selects mem_fwd_data.
  - else rf_readN_data.
  - rs=0 or uses_rs=0 always takes rf data.
- Load-use hazard (hz) when a used rsN != 0 matches either:
  - (ex_valid & ex_mem_read & ex_rd), or
  - (mem_valid & mem_mem_read & mem_rd).
- id_ready = advance & !hz & !flush.
- Edge priority, highest first:
  1. flush: ex_valid<=0.
  2. !advance: hold every ex_* register.
  3. advance & (hz | !id_valid): ex_valid<=0 (bubble); payload don't-care.
  4. advance & id_valid & !hz: load the payload; ex_op1/ex_op2 take the forwarded values.
- Bubbles force ex_reg_write=0 and ex_mem_read=0, so they never trigger forwarding or hazards.
- A load followed by a dependent instruction gives exactly two bubbles: one with the load in EX, one with it in MEM. The operand then arrives via the register-file WB bypass.
- rd=0 producers are never forwarded.
- Reset asserted mid-stall discards the held instruction.

Decomposition:
- common package:
  - RESET constant
  - fwd_sel_e enum {FWD_RF, FWD_EX, FWD_MEM}
  - id_ex_t packed struct (pc, op1, op2, imm, rd, reg_write, mem_read, ctrl)
- Sub-module operand_forward, combinational, instantiated once per operand:
  - inputs: rs, uses_rs, rf data, EX/MEM status/data
  - outputs: forwarded value, fwd_sel_e, hazard bit

Test Plan:
- Reset asserted asynchronously mid-cycle -> ex_valid=0 and ex_op1=0 immediately. After release with id_valid=1, rs1=3, rf_read1_data=0x11 -> next edge ex_valid=1, ex_op1=0x11.
- ADD x5 in ID/EX, ex_fwd_data=0xAA; next instruction rs1=5 with rf=0x00 -> ex_op1=0xAA. Same case with MEM rd=5, mem_fwd_data=0xBB also present -> ex_op1=0xAA (EX wins).
- LW x7 in ID/EX; dependent rs2=7 -> id_ready=0 for 2 cycles, two bubbles (ex_valid=0). Third cycle rf_read2_data=0xCC -> ex_op2=0xCC.
- ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable and id_ready=0; ex_ready=1 -> next instruction loaded on the following edge.
- flush=1 with id_valid=1 and ex_valid=1 -> id_ready=0, ex_valid=0 next edge.
- rs1=0 while EX has rd=0 and reg_write=1 -> no forward, no hazard, ex_op1=rf_read1_data.
